// File: rtl/count_sequence_checker.sv
// ---------------------------------------------------------------------------
// count_sequence_checker
//
// Receiving-end monitor for a loadable up/down step counter. It samples the
// counter output, predicts the next value from direction/value, locks onto the
// stream once enough consecutive predictions hold, and then flags every
// deviation with a one-cycle error pulse and a saturating error count.
//
// Ports:
//   clk        system clock, rising edge
//   set        asynchronous active-high reset
//   arm        enable checking; low forces IDLE
//   sample_en  count_in valid this cycle
//   count_in   counter output under check (WIDTH)
//   direction  1 = counting up, 0 = counting down
//   value      step size per sample, 0 = hold (4 bits, zero-extended)
//   locked     high while in TRACK
//   error      one-cycle pulse per mismatch seen in TRACK
//   err_count  saturating mismatch count (ERR_W)
//   expected   current prediction (WIDTH)
//   state      IDLE=0, SYNC=1, TRACK=2, HALT=3
//
// Optional build macro: CHECK_HALT_EN
//   Defined   : a TRACK mismatch parks the checker in HALT (prediction frozen,
//               samples ignored) until arm drops.
//   Undefined : a TRACK mismatch resyncs; HALT is unreachable and a decoded
//               HALT falls back to IDLE.
//
// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | disarmed or waiting for the first sample after arm
// SYNC  | seeded; counting consecutive correct predictions toward lock
// TRACK | locked; every mismatch is reported
// HALT  | frozen after a TRACK mismatch (CHECK_HALT_EN builds only)
// ---------------------------------------------------------------------------
module count_sequence_checker #(
    parameter int WIDTH    = 16,
    parameter int ERR_W    = 8,
    parameter int LOCK_LEN = 2      // must be >= 1
) (
    input  logic             clk,
    input  logic             set,
    input  logic             arm,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             direction,
    input  logic [3:0]       value,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // match_cnt counts samples in the current run including the seed sample,
    // so a run of LOCK_LEN correct predictions ends with match_cnt at
    // LOCK_LEN when the final correct sample arrives.
    localparam int MC_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
    localparam logic [MC_W-1:0] MC_ONE  = MC_W'(1);
    localparam logic [MC_W-1:0] MC_LOCK = MC_W'(LOCK_LEN);

    logic [MC_W-1:0]  match_cnt;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] pred;
    logic             hit;
    logic             err_sat;

    // Prediction from the current sample; WIDTH-bit arithmetic wraps modulo
    // 2^WIDTH in both directions.
    always_comb begin
        step    = {{(WIDTH-4){1'b0}}, value};
        pred    = direction ? (count_in + step) : (count_in - step);
        hit     = (count_in == expected);
        err_sat = &err_count;
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            state     <= S_IDLE;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            expected  <= '0;
            match_cnt <= '0;
        end else begin
            error <= 1'b0;
            // Disarm takes priority over any sample, including a mismatch in
            // the same cycle; err_count and expected are left for inspection.
            if (!arm) begin
                state  <= S_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sample_en) begin
                            expected  <= pred;
                            match_cnt <= MC_ONE;
                            err_count <= '0;
                            state     <= S_SYNC;
                        end
                    end

                    S_SYNC: begin
                        if (sample_en) begin
                            expected <= pred;
                            if (hit) begin
                                if (match_cnt == MC_LOCK) begin
                                    state  <= S_TRACK;
                                    locked <= 1'b1;
                                end else begin
                                    match_cnt <= match_cnt + MC_ONE;
                                end
                            end else begin
                                match_cnt <= MC_ONE;
                            end
                        end
                    end

                    S_TRACK: begin
                        if (sample_en) begin
                            if (hit) begin
                                expected <= pred;
                            end else begin
                                error     <= 1'b1;
                                locked    <= 1'b0;
                                match_cnt <= MC_ONE;
                                if (!err_sat) begin
                                    err_count <= err_count + 1'b1;
                                end
`ifdef CHECK_HALT_EN
                                // Prediction is frozen so the failing point
                                // remains visible.
                                state <= S_HALT;
`else
                                expected <= pred;
                                state    <= S_SYNC;
`endif
                            end
                        end
                    end

                    S_HALT: begin
`ifdef CHECK_HALT_EN
                        locked <= 1'b0;
`else
                        state  <= S_IDLE;
                        locked <= 1'b0;
`endif
                    end

                    default: begin
                        state  <= S_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

    logic        clk = 1'b0;
    logic        set;
    logic        arm;
    logic        sample_en;
    logic [15:0] count_in;
    logic        direction;
    logic [3:0]  value;
    logic        locked;
    logic        error;
    logic [7:0]  err_count;
    logic [15:0] expected;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_sequence_checker #(
        .WIDTH    (16),
        .ERR_W    (8),
        .LOCK_LEN (2)
    ) dut (
        .clk       (clk),
        .set       (set),
        .arm       (arm),
        .sample_en (sample_en),
        .count_in  (count_in),
        .direction (direction),
        .value     (value),
        .locked    (locked),
        .error     (error),
        .err_count (err_count),
        .expected  (expected),
        .state     (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] c);
        sample_en = 1'b1;
        count_in  = c;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic restart();
        arm = 1'b0;
        tick();
        arm = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set       = 1'b1;
        arm       = 1'b0;
        sample_en = 1'b0;
        count_in  = '0;
        direction = 1'b1;
        value     = 4'd1;
        #12;
        check_eq("rst_state",  32'(state), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_error",  32'(error), 0);
        check_eq("rst_errcnt", 32'(err_count), 0);
        check_eq("rst_exp",    32'(expected), 0);
        set = 1'b0;
        tick();

        // Up by 1 lock
        arm = 1'b1;
        tick();
        check_eq("idle_no_sample", 32'(state), 0);
        push(16'd100);
        check_eq("up1_s100_state", 32'(state), 1);
        check_eq("up1_s100_exp",   32'(expected), 101);
        check_eq("up1_s100_lock",  32'(locked), 0);
        push(16'd101);
        check_eq("up1_s101_state", 32'(state), 1);
        check_eq("up1_s101_lock",  32'(locked), 0);
        push(16'd102);
        check_eq("up1_s102_lock",  32'(locked), 1);
        check_eq("up1_s102_state", 32'(state), 2);
        check_eq("up1_s102_exp",   32'(expected), 103);
        push(16'd103);
        check_eq("up1_s103_exp",   32'(expected), 104);
        check_eq("up1_s103_err",   32'(error), 0);
        check_eq("up1_errcnt",     32'(err_count), 0);

        // Wrap upward by 2, then downward by 6 across zero
        restart();
        value = 4'd2;
        push(16'd65532);
        check_eq("wrap_seed_exp", 32'(expected), 65534);
        push(16'd65534);
        check_eq("wrap_top_exp", 32'(expected), 0);
        push(16'd0);
        check_eq("wrap_lock", 32'(locked), 1);
        check_eq("wrap_zero_exp", 32'(expected), 2);
        push(16'd2);
        check_eq("wrap_2_err", 32'(error), 0);
        direction = 1'b0;
        value     = 4'd6;
        push(16'd4);
        check_eq("down_exp", 32'(expected), 65534);
        push(16'd65534);
        check_eq("down_wrap_exp", 32'(expected), 65528);
        push(16'd65528);
        check_eq("down_err", 32'(error), 0);
        check_eq("down_lock", 32'(locked), 1);
        check_eq("down_errcnt", 32'(err_count), 0);

        // Gaps in a locked stream
        restart();
        direction = 1'b1;
        value     = 4'd1;
        push(16'd4);
        push(16'd5);
        push(16'd6);
        count_in = 16'd999;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("gap_state", 32'(state), 2);
            check_eq("gap_exp",   32'(expected), 7);
        end
        push(16'd7);
        check_eq("gap_7_err",   32'(error), 0);
        check_eq("gap_7_state", 32'(state), 2);
        check_eq("gap_7_exp",   32'(expected), 8);

        // Disarm in the same cycle as a mismatch: arm wins
        arm = 1'b0;
        push(16'd500);
        check_eq("disarm_state",  32'(state), 0);
        check_eq("disarm_err",    32'(error), 0);
        check_eq("disarm_lock",   32'(locked), 0);
        check_eq("disarm_exp",    32'(expected), 8);
        check_eq("disarm_errcnt", 32'(err_count), 0);
        arm = 1'b1;

`ifndef CHECK_HALT_EN
        // Glitch in TRACK, then relock
        restart();
        push(16'd10);
        push(16'd11);
        push(16'd12);
        check_eq("gl_lock", 32'(locked), 1);
        push(16'd20);
        check_eq("gl_err",    32'(error), 1);
        check_eq("gl_errcnt", 32'(err_count), 1);
        check_eq("gl_lock0",  32'(locked), 0);
        check_eq("gl_state",  32'(state), 1);
        check_eq("gl_exp",    32'(expected), 21);
        tick();
        check_eq("gl_pulse_end", 32'(error), 0);
        push(16'd21);
        check_eq("gl_21_state", 32'(state), 1);
        check_eq("gl_21_err",   32'(error), 0);
        push(16'd22);
        check_eq("gl_relock",  32'(locked), 1);
        check_eq("gl_22_exp",  32'(expected), 23);
        check_eq("gl_errcnt2", 32'(err_count), 1);

        // Three errors, then asynchronous reset between edges
        restart();
        push(16'd0);
        push(16'd1);
        push(16'd2);
        push(16'd50);
        push(16'd51);
        push(16'd52);
        push(16'd80);
        push(16'd81);
        push(16'd82);
        push(16'd90);
        push(16'd91);
        push(16'd92);
        check_eq("e3_errcnt", 32'(err_count), 3);
        check_eq("e3_state",  32'(state), 2);
        #3;
        set = 1'b1;
        #1;
        check_eq("arst_state",  32'(state), 0);
        check_eq("arst_locked", 32'(locked), 0);
        check_eq("arst_errcnt", 32'(err_count), 0);
        check_eq("arst_exp",    32'(expected), 0);
        #2;
        set = 1'b0;
        tick();

        // Error counter saturation
        push(16'd0);
        push(16'd1);
        push(16'd2);
        for (int i = 0; i < 259; i++) begin
            push(16'd1000);
            push(16'd1001);
            push(16'd1002);
        end
        check_eq("sat_errcnt", 32'(err_count), 255);
        check_eq("sat_state",  32'(state), 2);
        push(16'd1000);
        check_eq("sat_err",     32'(error), 1);
        check_eq("sat_errcnt2", 32'(err_count), 255);
`else
        // Halt on first TRACK mismatch
        restart();
        push(16'd0);
        push(16'd1);
        push(16'd2);
        check_eq("halt_lock", 32'(locked), 1);
        push(16'd9);
        check_eq("halt_state",  32'(state), 3);
        check_eq("halt_err",    32'(error), 1);
        check_eq("halt_errcnt", 32'(err_count), 1);
        check_eq("halt_exp",    32'(expected), 3);
        push(16'd10);
        check_eq("halt_err2",   32'(error), 0);
        push(16'd11);
        check_eq("halt_state2", 32'(state), 3);
        check_eq("halt_exp2",   32'(expected), 3);
        check_eq("halt_errcnt2", 32'(err_count), 1);
        check_eq("halt_lock0",  32'(locked), 0);
        arm = 1'b0;
        tick();
        check_eq("halt_idle", 32'(state), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
